// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream in and instruction-memory write port out of the loader.
interface instr_mem_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a length-prefixed little-endian byte frame into instruction memory.
// Defining ILOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in state CSUM.
module instr_mem_loader #(
   parameter int          IMEM_SIZE = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_start,
   instr_mem_loader_if.slave   bus,
   output logic                cpu_hold,
   output logic                load_done,
   output logic                load_error
);
   localparam int CW = $clog2(IMEM_SIZE + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
`ifdef ILOADER_CHECKSUM_EN
      , S_CSUM = 3'd5
`endif
   } state_t;

`ifdef ILOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CSUM;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t        state_q, state_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [23:0]   asm_q, asm_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [31:0]   waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;
`ifdef ILOADER_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   logic          in_ready_c;
   logic          accept;
   logic          last_byte;
   logic [31:0]   word;
   logic [CW-1:0] cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         byte_idx_q <= '0;
         asm_q      <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
`ifdef ILOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
`ifdef ILOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
`ifdef ILOADER_CHECKSUM_EN
      csum_d     = csum_q;
      in_ready_c = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
      in_ready_c = (state_q == S_LEN) || (state_q == S_DATA);
`endif
      accept    = bus.in_valid && in_ready_c;
      last_byte = (byte_idx_q == 2'd3);
      // Bytes enter at the top and shift down, so the first byte ends up in bits [7:0].
      word      = {bus.in_data, asm_q};
      cnt_next  = cnt_q + CW'(1);

      if (accept) begin
         byte_idx_d = byte_idx_q + 2'd1;
         asm_d      = {bus.in_data, asm_q[23:8]};
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (load_start) begin
               state_d    = S_LEN;
               byte_idx_d = '0;
               len_d      = '0;
               cnt_d      = '0;
`ifdef ILOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         S_LEN: begin
            if (accept && last_byte) begin
               if (word == 32'd0) begin
                  state_d = S_TAIL;
               end else if (word > 32'(IMEM_SIZE)) begin
                  state_d = S_ERR;
               end else begin
                  len_d   = word[CW-1:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
`ifdef ILOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               if (last_byte) begin
                  we_d    = 1'b1;
                  wdata_d = word;
                  waddr_d = BASE_ADDR + (32'(cnt_q) << 2);
                  cnt_d   = cnt_next;
                  if (cnt_next == len_q) state_d = S_TAIL;
               end
            end
         end
`ifdef ILOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.imem_we    = we_q;
   assign bus.imem_waddr = waddr_q;
   assign bus.imem_wdata = wdata_q;
   assign cpu_hold       = in_ready_c || (state_q == S_ERR);
   assign load_done      = (state_q == S_DONE);
   assign load_error     = (state_q == S_ERR);
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;
   localparam int          IMEM_SIZE = 1024;
   localparam logic [31:0] BASE      = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic load_start = 1'b0;
   logic cpu_hold, load_done, load_error;

   instr_mem_loader_if bus ();

   instr_mem_loader #(.IMEM_SIZE(IMEM_SIZE), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] words[$];

   always @(negedge clk) if (bus.imem_we === 1'b1) got_q.push_back({bus.imem_waddr, bus.imem_wdata});

   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise);
      bit ok = 1'b0;
      int n  = 0;
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            load_start   = noise && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
         end
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (!ok && n < 40) begin
         load_start = noise && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk); #1;
         n++;
      end
      load_start = 1'b0;
      if (!ok) chk("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   // Sends one frame from words[] and checks it against the frame rules.
   task automatic run_frame(input string tag, input logic [31:0] n, input bit gaps, input bit noise,
                            input bit bad_csum, input bit exp_done, input bit exp_err, input int exp_nw);
      logic [7:0] cs = 8'h00;
      logic [31:0] w;
      int mism = 0;
      got_q.delete();
      exp_q.delete();
      pulse_start();
      chk({tag, "_hold_at_start"}, cpu_hold, 1);
      chk({tag, "_ready_at_start"}, bus.in_ready, 1);
      for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gaps, noise);
      if (n <= IMEM_SIZE) begin
         for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            exp_q.push_back({BASE + 32'(4 * i), w});
            for (int k = 0; k < 4; k++) begin
               cs = cs ^ w[8*k +: 8];
               send_byte(w[8*k +: 8], gaps, noise);
            end
         end
`ifdef ILOADER_CHECKSUM_EN
         send_byte(bad_csum ? (cs ^ 8'h5A) : cs, gaps, 1'b0);
`endif
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_done"}, load_done, exp_done);
      chk({tag, "_error"}, load_error, exp_err);
      chk({tag, "_cpu_hold"}, cpu_hold, exp_err);
      chk({tag, "_in_ready_idle"}, bus.in_ready, 0);
      chk({tag, "_write_count"}, 64'(got_q.size()), 64'(exp_nw));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) mism++;
      chk({tag, "_write_contents"}, 64'(mism), 0);
      if (exp_q.size() > 0) chk({tag, "_port_holds"}, {bus.imem_waddr, bus.imem_wdata}, exp_q[$]);
   endtask

   typedef struct {
      logic [31:0] n;
      bit          exp_done;
      bit          exp_err;
      int          exp_nw;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{32'd2,          1'b1, 1'b0, 2};
      tbl[1] = '{32'd0,          1'b1, 1'b0, 0};
      tbl[2] = '{32'd1025,       1'b0, 1'b1, 0};
      tbl[3] = '{32'd1,          1'b1, 1'b0, 1};
      tbl[4] = '{32'hFFFF_FFFF,  1'b0, 1'b1, 0};
      tbl[5] = '{32'd1024,       1'b1, 1'b0, 1024};
      tbl[6] = '{32'd3,          1'b1, 1'b0, 3};

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      #2 rst_n = 1'b0;
      #1;
      chk("reset_in_ready", bus.in_ready, 0);
      chk("reset_we", bus.imem_we, 0);
      chk("reset_waddr", bus.imem_waddr, 0);
      chk("reset_wdata", bus.imem_wdata, 0);
      chk("reset_cpu_hold", cpu_hold, 0);
      chk("reset_done", load_done, 0);
      chk("reset_error", load_error, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", bus.in_ready, 0);

      for (int t = 0; t < 7; t++) begin
         words.delete();
         words.push_back(32'h0000_0013);
         words.push_back(32'h0010_8093);
         for (int i = 2; i < 1024; i++) words.push_back($urandom);
         run_frame($sformatf("vec%0d", t), tbl[t].n, 1'b0, 1'b0, 1'b0,
                   tbl[t].exp_done, tbl[t].exp_err, tbl[t].exp_nw);
      end

      for (int r = 0; r < 6; r++) begin
         int n = $urandom_range(1, 12);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back($urandom);
         run_frame($sformatf("rand%0d", r), 32'(n), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, n);
      end

      words.delete();
      words.push_back(32'h0000_0013);
      words.push_back(32'h0010_8093);
      run_frame("gaps_basic", 32'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2);
      chk("gaps_basic_first", got_q.size() > 0 ? got_q[0] : 64'd0, {32'h0, 32'h0000_0013});

`ifdef ILOADER_CHECKSUM_EN
      run_frame("bad_csum", 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
`endif

      got_q.delete();
      pulse_start();
      send_byte(8'h02, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 1'b0, 1'b0);
      send_byte(words[1][7:0], 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", bus.in_ready, 0);
      chk("midrst_we", bus.imem_we, 0);
      chk("midrst_waddr", bus.imem_waddr, 0);
      chk("midrst_wdata", bus.imem_wdata, 0);
      chk("midrst_cpu_hold", cpu_hold, 0);
      chk("midrst_done_err", {load_done, load_error}, 0);
      chk("midrst_writes", 64'(got_q.size()), 1);
      chk("midrst_write0", got_q.size() > 0 ? got_q[0] : 64'd0, {BASE, words[0]});
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after_rst_idle_ready", bus.in_ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
